// File: rtl/logo_scroll_ctrl.sv
// Logo scroll controller: frame-synchronous horizontal offset for the logo painters.
// Sweeps delt from 0 to DELT_MAX, pauses, sweeps back, pauses, and repeats, with all
// updates aligned to a synchronised vertical-sync edge so no frame shows a torn logo.
module logo_scroll_ctrl #(
  parameter int unsigned DELT_MAX        = 200,
  parameter int unsigned STEP            = 2,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned PAUSE_FRAMES    = 60,
  parameter bit          VS_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        start,
  input  logic        stop,
  output logic [10:0] delt,
  output logic        logo_en,
  output logic        dir,
  output logic        stop_pend
);

  // Counters only ever reach N-1, so $clog2(N) bits suffice (minimum one bit).
  localparam int unsigned FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [FW-1:0] FrameLast = FW'(FRAMES_PER_STEP - 1);
  localparam logic [PW-1:0] PauseLast = PW'(PAUSE_FRAMES - 1);
  localparam logic [11:0]   Max12     = 12'(DELT_MAX);
  localparam logic [11:0]   Step12    = 12'(STEP);
  localparam logic [10:0]   Max11     = 11'(DELT_MAX);
  localparam logic [10:0]   Step11    = 11'(STEP);

  // Level of vsync outside the sync pulse.
  localparam logic VsIdle = VS_ACTIVE_LOW;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFwd      = 3'd1;
  localparam logic [2:0] StHoldEnd  = 3'd2;
  localparam logic [2:0] StRev      = 3'd3;
  localparam logic [2:0] StHoldHome = 3'd4;

  logic          vs_s1_q, vs_s2_q, vs_h_q;
  logic          tick;
  logic [2:0]    state_q, state_d;
  logic [10:0]   delt_q, delt_d;
  logic          dir_q, dir_d;
  logic          pend_q, pend_d;
  logic          en_q, en_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [11:0]   sum;

  // Two-flop synchroniser plus history flop for vsync edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1_q <= VsIdle;
      vs_s2_q <= VsIdle;
      vs_h_q  <= VsIdle;
    end else begin
      vs_s1_q <= vsync;
      vs_s2_q <= vs_s1_q;
      vs_h_q  <= vs_s2_q;
    end
  end

  // One tick per vsync pulse: synchronised level asserted, previous level not.
  assign tick = (vs_s2_q != VsIdle) && (vs_h_q == VsIdle);

  // 12-bit sum so the clamp test cannot be fooled by an 11-bit wrap.
  assign sum = {1'b0, delt_q} + Step12;

  // Next-state logic for the sweep FSM, counters and stop handshake.
  always_comb begin
    state_d = state_q;
    delt_d  = delt_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    frame_d = frame_q;
    pause_d = pause_q;

    if (state_q == StIdle) begin
      if (start && !stop) begin
        state_d = StFwd;
        delt_d  = '0;
        dir_d   = 1'b0;
        frame_d = '0;
        pause_d = '0;
      end
    end else if (pend_q && tick) begin
      // Pending stop beats any step or phase change on this tick.
      state_d = StIdle;
      delt_d  = '0;
      dir_d   = 1'b0;
      pend_d  = 1'b0;
      frame_d = '0;
      pause_d = '0;
    end else begin
      if (stop) begin
        pend_d = 1'b1;
      end
      if (tick) begin
        case (state_q)
          StFwd: begin
            if (frame_q == FrameLast) begin
              frame_d = '0;
              if (sum >= Max12) begin
                delt_d  = Max11;
                state_d = StHoldEnd;
                pause_d = '0;
              end else begin
                delt_d = sum[10:0];
              end
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
          StHoldEnd: begin
            if (pause_q == PauseLast) begin
              state_d = StRev;
              dir_d   = 1'b1;
              pause_d = '0;
              frame_d = '0;
            end else begin
              pause_d = pause_q + 1'b1;
            end
          end
          StRev: begin
            if (frame_q == FrameLast) begin
              frame_d = '0;
              if ({1'b0, delt_q} <= Step12) begin
                delt_d  = '0;
                state_d = StHoldHome;
                pause_d = '0;
              end else begin
                delt_d = delt_q - Step11;
              end
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
          StHoldHome: begin
            if (pause_q == PauseLast) begin
              state_d = StFwd;
              dir_d   = 1'b0;
              pause_d = '0;
              frame_d = '0;
            end else begin
              pause_d = pause_q + 1'b1;
            end
          end
          default: begin
            state_d = StIdle;
            delt_d  = '0;
            dir_d   = 1'b0;
            pend_d  = 1'b0;
            frame_d = '0;
            pause_d = '0;
          end
        endcase
      end
    end

    en_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      delt_q  <= '0;
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      frame_q <= '0;
      pause_q <= '0;
    end else begin
      state_q <= state_d;
      delt_q  <= delt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      frame_q <= frame_d;
      pause_q <= pause_d;
    end
  end

  assign delt      = delt_q;
  assign logo_en   = en_q;
  assign dir       = dir_q;
  assign stop_pend = pend_q;

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Directed bench for logo_scroll_ctrl: two instances (DELT_MAX=20 and 18) share stimulus.
module tb_logo_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        start;
  logic        stop;
  logic [10:0] delt_a, delt_b;
  logic        en_a, en_b, dir_a, dir_b, pend_a, pend_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int da;
    int db;
    int dr;
  } vec_t;

  vec_t tbl[27];

  always #5 clk = ~clk;

  logo_scroll_ctrl #(
    .DELT_MAX(20), .STEP(4), .FRAMES_PER_STEP(2), .PAUSE_FRAMES(3), .VS_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .stop(stop),
    .delt(delt_a), .logo_en(en_a), .dir(dir_a), .stop_pend(pend_a)
  );

  logo_scroll_ctrl #(
    .DELT_MAX(18), .STEP(4), .FRAMES_PER_STEP(2), .PAUSE_FRAMES(3), .VS_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .stop(stop),
    .delt(delt_b), .logo_en(en_b), .dir(dir_b), .stop_pend(pend_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Low vsync pulse of the given width, then enough idle cycles for the tick to land.
  task automatic vs_pulse(input int width);
    @(negedge clk);
    vsync = 1'b0;
    repeat (width) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_in(input logic s, input logic p);
    @(negedge clk);
    start = s;
    stop  = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0};   tbl[1]  = '{4, 4, 0};   tbl[2]  = '{4, 4, 0};
    tbl[3]  = '{8, 8, 0};   tbl[4]  = '{8, 8, 0};   tbl[5]  = '{12, 12, 0};
    tbl[6]  = '{12, 12, 0}; tbl[7]  = '{16, 16, 0}; tbl[8]  = '{16, 16, 0};
    tbl[9]  = '{20, 18, 0}; tbl[10] = '{20, 18, 0}; tbl[11] = '{20, 18, 0};
    tbl[12] = '{20, 18, 1}; tbl[13] = '{20, 18, 1}; tbl[14] = '{16, 14, 1};
    tbl[15] = '{16, 14, 1}; tbl[16] = '{12, 10, 1}; tbl[17] = '{12, 10, 1};
    tbl[18] = '{8, 6, 1};   tbl[19] = '{8, 6, 1};   tbl[20] = '{4, 2, 1};
    tbl[21] = '{4, 2, 1};   tbl[22] = '{0, 0, 1};   tbl[23] = '{0, 0, 1};
    tbl[24] = '{0, 0, 1};   tbl[25] = '{0, 0, 0};   tbl[26] = '{0, 0, 0};

    rst   = 1'b0;
    vsync = 1'b1;
    start = 1'b0;
    stop  = 1'b0;

    // Reset held with vsync toggling.
    for (int i = 0; i < 4; i++) begin
      #3 vsync = ~vsync;
    end
    chk("rst delt", int'(delt_a), 0);
    chk("rst logo_en", int'(en_a), 0);
    chk("rst dir", int'(dir_a), 0);
    chk("rst stop_pend", int'(pend_a), 0);
    vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Start: enable one cycle later, offset still zero.
    pulse_in(1'b1, 1'b0);
    chk("start logo_en", int'(en_a), 1);
    chk("start delt", int'(delt_a), 0);

    // Full sweep out, pause, sweep back, pause.
    for (int i = 0; i < 27; i++) begin
      vs_pulse(1);
      chk($sformatf("tick%0d delt_a", i + 1), int'(delt_a), tbl[i].da);
      chk($sformatf("tick%0d delt_b", i + 1), int'(delt_b), tbl[i].db);
      chk($sformatf("tick%0d dir_a", i + 1), int'(dir_a), tbl[i].dr);
      chk($sformatf("tick%0d dir_b", i + 1), int'(dir_b), tbl[i].dr);
      chk($sformatf("tick%0d logo_en", i + 1), int'(en_a), 1);
    end

    // Tick 28 is a step tick: delt must change exactly on the 3rd edge after vsync falls.
    @(negedge clk);
    vsync = 1'b0;
    @(posedge clk);
    #1;
    chk("edge1 delt", int'(delt_a), 0);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    #1;
    chk("edge2 delt", int'(delt_a), 0);
    @(posedge clk);
    #1;
    chk("edge3 delt", int'(delt_a), 4);
    repeat (3) @(negedge clk);

    // Advance to delt=12 with the next tick being a step tick.
    for (int i = 0; i < 5; i++) vs_pulse(1);
    chk("pre-stop delt_a", int'(delt_a), 12);
    chk("pre-stop delt_b", int'(delt_b), 12);

    // Stop mid-sweep: pending until the next tick, which would otherwise step.
    pulse_in(1'b0, 1'b1);
    chk("stop_pend set", int'(pend_a), 1);
    chk("stop hold delt", int'(delt_a), 12);
    repeat (3) @(negedge clk);
    chk("stop still 12", int'(delt_a), 12);
    pulse_in(1'b1, 1'b0);
    chk("start while pend", int'(en_a), 1);
    vs_pulse(1);
    chk("stop delt", int'(delt_a), 0);
    chk("stop logo_en", int'(en_a), 0);
    chk("stop stop_pend", int'(pend_a), 0);
    chk("stop dir", int'(dir_a), 0);
    chk("stop logo_en_b", int'(en_b), 0);

    // Stop in IDLE does nothing; start+stop together keeps IDLE.
    pulse_in(1'b0, 1'b1);
    chk("idle stop pend", int'(pend_a), 0);
    pulse_in(1'b1, 1'b1);
    @(negedge clk);
    chk("start+stop logo_en", int'(en_a), 0);

    // Restart, ignore a second start, then a wide vsync pulse gives only one tick.
    pulse_in(1'b1, 1'b0);
    chk("restart logo_en", int'(en_a), 1);
    pulse_in(1'b1, 1'b0);
    chk("start in fwd en", int'(en_a), 1);
    chk("start in fwd delt", int'(delt_a), 0);
    vs_pulse(5);
    chk("wide pulse delt", int'(delt_a), 0);
    vs_pulse(1);
    chk("after wide delt_a", int'(delt_a), 4);
    chk("after wide delt_b", int'(delt_b), 4);

    // Asynchronous reset mid-clock, checked before the next edge.
    @(posedge clk);
    #3;
    vsync = 1'b0;
    rst   = 1'b0;
    #1;
    chk("async rst delt", int'(delt_a), 0);
    chk("async rst logo_en", int'(en_a), 0);
    chk("async rst dir", int'(dir_a), 0);
    chk("async rst stop_pend", int'(pend_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
